// File: rtl/rv32i_types_pkg.sv
// Shared dispatch types: FU selector, CB tag type and the held-instruction record.
package rv32i_types_pkg;

   localparam int CB_ENTRIES = 16;
   localparam int CB_IDX_W   = $clog2(CB_ENTRIES);
   localparam int CB_NUM_FU  = 4;

   typedef logic [6:0] opcode_t;
   localparam opcode_t OP_BUBBLE = 7'h00;

   typedef enum logic [1:0] {
      FU_ARITH = 2'd0,
      FU_MUL   = 2'd1,
      FU_DIV   = 2'd2,
      FU_LS    = 2'd3
   } fu_sel_t;

   typedef logic [CB_IDX_W-1:0] cb_index_t;

   typedef struct packed {
      cb_index_t  index;
      fu_sel_t    fu;
      logic [4:0] rd;
      logic       wen;
   } dispatch_entry_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HELD  = 1'b1
   } tag_state_t;

endpackage

// File: rtl/cb_occupancy_counter.sv
// Mirror of the CB entry count: up on allocate, down on retire, clear on flush.
// Saturates at 0 and MAX so a stray retire at empty cannot underflow.
module cb_occupancy_counter #(
   parameter int MAX   = 16,
   parameter int CNT_W = $clog2(MAX) + 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             up,
   input  logic             down,
   input  logic             clear,
   output logic [CNT_W-1:0] count,
   output logic             at_cap
);

   // Count register; simultaneous up and down cancel out.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (up && !down && (count != CNT_W'(MAX)))
         count <= count + 1'b1;
      else if (down && !up && (count != '0))
         count <= count - 1'b1;
   end

   assign at_cap = (count == CNT_W'(MAX));

endmodule

// File: rtl/cb_dispatch_tagger.sv
// Completion-buffer dispatch tagger: accepts decoded instructions, allocates a CB
// entry, tags the instruction with the CB tail index and holds it in a single
// output register until the target FU accepts it.
// Optional: define CB_DISPATCH_STATS_EN for stall/dispatch counters.
module cb_dispatch_tagger
   import rv32i_types_pkg::*;
#(
   parameter int NUM_ENTRY = 16,
   parameter int NUM_FU    = 4,
   parameter int IDX_W     = $clog2(NUM_ENTRY)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              dec_valid,
   output logic              dec_ready,
   input  logic [6:0]        dec_opcode,
   input  logic [1:0]        dec_fu,
   input  logic [4:0]        dec_rd,
   input  logic              dec_wen,
   output logic              alloc_ena,
   output logic [6:0]        alloc_opcode,
   input  logic [IDX_W-1:0]  cb_tail,
   input  logic              cb_full,
   input  logic              cb_commit,
   input  logic              flush,
   output logic [NUM_FU-1:0] iss_valid,
   input  logic [NUM_FU-1:0] iss_ready,
   output logic [IDX_W-1:0]  iss_index,
   output logic [4:0]        iss_rd,
   output logic              iss_wen,
`ifdef CB_DISPATCH_STATS_EN
   output logic [31:0]       stall_full_cnt,
   output logic [31:0]       dispatch_cnt,
`endif
   output logic [IDX_W:0]    occupancy
);

   tag_state_t      state_q, state_d;
   dispatch_entry_t held_q;
   logic            at_cap;
   logic            can_alloc;
   logic            bubble;
   logic            drain;
   logic            accept;

   assign can_alloc = ~cb_full & ~at_cap & ~flush;
   assign bubble    = (dec_opcode == OP_BUBBLE);

   // Ready/accept decode and EMPTY/HELD next state; flush overrides everything.
   always_comb begin
      state_d   = state_q;
      drain     = (state_q == ST_HELD) & iss_ready[held_q.fu];
      dec_ready = ~RST & ~flush & (bubble | (can_alloc & ((state_q == ST_EMPTY) | drain)));
      accept    = dec_valid & dec_ready & ~bubble;
      if (flush)
         state_d = ST_EMPTY;
      else if (accept)
         state_d = ST_HELD;
      else if (drain)
         state_d = ST_EMPTY;
   end

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         state_q <= ST_EMPTY;
      else
         state_q <= state_d;
   end

   // Capture tag and destination of the accepted instruction; held stable otherwise.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         held_q <= '0;
      else if (accept)
         held_q <= '{index: cb_index_t'(cb_tail), fu: fu_sel_t'(dec_fu), rd: dec_rd, wen: dec_wen};
   end

   assign alloc_ena    = accept;
   assign alloc_opcode = dec_opcode;
   assign iss_valid    = (state_q == ST_HELD) ? (NUM_FU'(1) << held_q.fu) : '0;
   assign iss_index    = IDX_W'(held_q.index);
   assign iss_rd       = held_q.rd;
   assign iss_wen      = held_q.wen;

   cb_occupancy_counter #(
      .MAX   (NUM_ENTRY),
      .CNT_W (IDX_W + 1)
   ) u_occ (
      .CLK    (CLK),
      .RST    (RST),
      .up     (accept),
      .down   (cb_commit),
      .clear  (flush),
      .count  (occupancy),
      .at_cap (at_cap)
   );

`ifdef CB_DISPATCH_STATS_EN
   // Saturating statistics; only RST clears them, flush leaves them alone.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stall_full_cnt <= '0;
         dispatch_cnt   <= '0;
      end else begin
         if (dec_valid && !can_alloc && !flush && (stall_full_cnt != 32'hFFFF_FFFF))
            stall_full_cnt <= stall_full_cnt + 32'd1;
         if (accept && (dispatch_cnt != 32'hFFFF_FFFF))
            dispatch_cnt <= dispatch_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cb_dispatch_tagger.sv
// Self-checking bench for cb_dispatch_tagger: directed scenarios plus a randomized
// run, all compared against a behavioural model of the dispatch rules.
module tb_cb_dispatch_tagger;

   localparam int NE = 16;
   localparam int IW = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          dec_valid = 1'b0;
   logic          dec_ready;
   logic [6:0]    dec_opcode = '0;
   logic [1:0]    dec_fu = '0;
   logic [4:0]    dec_rd = '0;
   logic          dec_wen = 1'b0;
   logic          alloc_ena;
   logic [6:0]    alloc_opcode;
   logic [IW-1:0] cb_tail = '0;
   logic          cb_full = 1'b0;
   logic          cb_commit = 1'b0;
   logic          flush = 1'b0;
   logic [3:0]    iss_valid;
   logic [3:0]    iss_ready = '0;
   logic [IW-1:0] iss_index;
   logic [4:0]    iss_rd;
   logic          iss_wen;
   logic [IW:0]   occupancy;
`ifdef CB_DISPATCH_STATS_EN
   logic [31:0]   stall_full_cnt;
   logic [31:0]   dispatch_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: is an instruction held, where, and how many CB entries are live.
   bit      m_held;
   int      m_fu, m_idx, m_rd, m_wen, m_occ;
   longint  m_stall, m_disp;

   always #5 CLK = ~CLK;

   cb_dispatch_tagger #(.NUM_ENTRY(NE), .NUM_FU(4)) dut (
      .CLK(CLK), .RST(RST),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode),
      .dec_fu(dec_fu), .dec_rd(dec_rd), .dec_wen(dec_wen),
      .alloc_ena(alloc_ena), .alloc_opcode(alloc_opcode),
      .cb_tail(cb_tail), .cb_full(cb_full), .cb_commit(cb_commit), .flush(flush),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_index(iss_index),
      .iss_rd(iss_rd), .iss_wen(iss_wen),
`ifdef CB_DISPATCH_STATS_EN
      .stall_full_cnt(stall_full_cnt), .dispatch_cnt(dispatch_cnt),
`endif
      .occupancy(occupancy)
   );

   function automatic bit exp_ready();
      if (RST || flush) return 1'b0;
      if (dec_opcode == 7'd0) return 1'b1;
      return !cb_full && (m_occ < NE) && (!m_held || iss_ready[m_fu]);
   endfunction

   function automatic bit exp_alloc();
      return dec_valid && exp_ready() && (dec_opcode != 7'd0);
   endfunction

   function automatic logic [3:0] exp_iss_valid();
      return m_held ? (4'b0001 << m_fu) : 4'b0000;
   endfunction

   task automatic model_reset();
      m_held = 0; m_fu = 0; m_idx = 0; m_rd = 0; m_wen = 0; m_occ = 0;
      m_stall = 0; m_disp = 0;
   endtask

   // Advance one clock; the model consumes the inputs that were present at the edge.
   task automatic tick();
      bit acc, drn, stall;
      @(posedge CLK);
      acc   = exp_alloc();
      drn   = m_held && iss_ready[m_fu];
      stall = dec_valid && !flush && (cb_full || m_occ >= NE);
      if (RST) model_reset();
      else begin
         if (stall) m_stall++;
         if (acc) m_disp++;
         if (flush) begin
            m_held = 0; m_occ = 0;
         end else begin
            if (acc) begin
               m_held = 1; m_fu = dec_fu; m_idx = cb_tail; m_rd = dec_rd; m_wen = dec_wen;
            end else if (drn) m_held = 0;
            if (acc && !cb_commit && m_occ < NE) m_occ++;
            else if (cb_commit && !acc && m_occ > 0) m_occ--;
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      dec_valid = 0; dec_opcode = 0; dec_fu = 0; dec_rd = 0; dec_wen = 0;
      cb_tail = 0; cb_full = 0; cb_commit = 0; flush = 0; iss_ready = 4'b1111;
   endtask

   task automatic do_reset();
      idle_inputs();
      RST = 1;
      tick(); tick();
      RST = 0;
      #1;
   endtask

   task automatic set_dec(input logic [6:0] op, input int fu, input int tail, input int rd, input bit wen);
      dec_valid = 1; dec_opcode = op; dec_fu = fu[1:0]; cb_tail = tail[IW-1:0];
      dec_rd = rd[4:0]; dec_wen = wen;
   endtask

   task automatic test_reset();
      idle_inputs();
      RST = 1; set_dec(7'h33, 0, 3, 1, 1);
      #2;
      n_vec++; if (dec_ready !== 1'b0) begin n_err++; $display("FAIL reset_dec_ready got %b want 0", dec_ready); end
      n_vec++; if (alloc_ena !== 1'b0) begin n_err++; $display("FAIL reset_alloc_ena got %b want 0", alloc_ena); end
      n_vec++; if (iss_valid !== 4'b0) begin n_err++; $display("FAIL reset_iss_valid got %b want 0000", iss_valid); end
      n_vec++; if ({iss_index, iss_rd, iss_wen} !== '0) begin n_err++; $display("FAIL reset_iss_fields got %h/%h/%b want 0", iss_index, iss_rd, iss_wen); end
      n_vec++; if (occupancy !== '0) begin n_err++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
      tick();
      RST = 0; dec_valid = 0;
      model_reset();
      #1;
      n_vec++; if (dec_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_dec_ready got %b want 1", dec_ready); end
   endtask

   task automatic test_basic_issue();
      do_reset();
      set_dec(7'h33, 0, 5, 10, 1);
      #1;
      n_vec++; if (alloc_ena !== 1'b1) begin n_err++; $display("FAIL basic_alloc_ena got %b want 1", alloc_ena); end
      n_vec++; if (alloc_opcode !== 7'h33) begin n_err++; $display("FAIL basic_alloc_opcode got %h want 33", alloc_opcode); end
      tick();
      dec_valid = 0;
      #1;
      n_vec++; if (iss_valid !== 4'b0001) begin n_err++; $display("FAIL basic_iss_valid got %b want 0001", iss_valid); end
      n_vec++; if (iss_index !== 4'd5) begin n_err++; $display("FAIL basic_iss_index got %0d want 5", iss_index); end
      n_vec++; if (iss_rd !== 5'd10 || iss_wen !== 1'b1) begin n_err++; $display("FAIL basic_iss_rd_wen got %0d/%b want 10/1", iss_rd, iss_wen); end
      n_vec++; if (occupancy !== 5'd1) begin n_err++; $display("FAIL basic_occupancy got %0d want 1", occupancy); end
      tick();
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < NE; i++) begin
         set_dec(7'h13, i % 4, i, i, 1);
         #1;
         n_vec++; if (alloc_ena !== 1'b1) begin n_err++; $display("FAIL full_fill_alloc[%0d] got %b want 1", i, alloc_ena); end
         tick();
      end
      set_dec(7'h13, 0, 0, 0, 0);
      #1;
      n_vec++; if (dec_ready !== 1'b0) begin n_err++; $display("FAIL full_17th_ready got %b want 0", dec_ready); end
      n_vec++; if (alloc_ena !== 1'b0) begin n_err++; $display("FAIL full_17th_alloc got %b want 0", alloc_ena); end
      n_vec++; if (occupancy !== 5'd16) begin n_err++; $display("FAIL full_occupancy got %0d want 16", occupancy); end
      dec_valid = 0; cb_commit = 1;
      tick();
      cb_commit = 0; set_dec(7'h13, 1, 0, 2, 1);
      #1;
      n_vec++; if (dec_ready !== 1'b1) begin n_err++; $display("FAIL full_after_commit_ready got %b want 1", dec_ready); end
      n_vec++; if (occupancy !== 5'd15) begin n_err++; $display("FAIL full_after_commit_occ got %0d want 15", occupancy); end
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      iss_ready = 4'b0000;
      set_dec(7'h3B, 1, 7, 9, 1);
      tick();
      set_dec(7'h33, 0, 8, 4, 0);
      for (int c = 0; c < 3; c++) begin
         #1;
         n_vec++; if (iss_valid !== 4'b0010) begin n_err++; $display("FAIL bp_iss_valid[%0d] got %b want 0010", c, iss_valid); end
         n_vec++; if (iss_index !== 4'd7) begin n_err++; $display("FAIL bp_iss_index[%0d] got %0d want 7", c, iss_index); end
         n_vec++; if (dec_ready !== 1'b0) begin n_err++; $display("FAIL bp_dec_ready[%0d] got %b want 0", c, dec_ready); end
         tick();
      end
      iss_ready = 4'b0010;
      #1;
      n_vec++; if (dec_ready !== 1'b1 || alloc_ena !== 1'b1) begin n_err++; $display("FAIL bp_drain_accept got %b/%b want 1/1", dec_ready, alloc_ena); end
      tick();
      dec_valid = 0;
      #1;
      n_vec++; if (iss_valid !== 4'b0001 || iss_index !== 4'd8) begin n_err++; $display("FAIL bp_next_issue got %b/%0d want 0001/8", iss_valid, iss_index); end
      n_vec++; if (occupancy !== 5'd2) begin n_err++; $display("FAIL bp_occupancy got %0d want 2", occupancy); end
   endtask

   task automatic test_flush();
      do_reset();
      iss_ready = 4'b0000;
      set_dec(7'h03, 3, 2, 6, 1);
      tick();
      flush = 1; set_dec(7'h33, 0, 3, 1, 1);
      #1;
      n_vec++; if (alloc_ena !== 1'b0) begin n_err++; $display("FAIL flush_alloc got %b want 0", alloc_ena); end
      n_vec++; if (dec_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got %b want 0", dec_ready); end
      tick();
      flush = 0; dec_valid = 0;
      #1;
      n_vec++; if (iss_valid !== 4'b0000) begin n_err++; $display("FAIL flush_iss_valid got %b want 0000", iss_valid); end
      n_vec++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL flush_occupancy got %0d want 0", occupancy); end
   endtask

   task automatic test_commit_bubble();
      do_reset();
      cb_commit = 1;
      tick();
      cb_commit = 0;
      #1;
      n_vec++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL commit_at_zero got %0d want 0", occupancy); end
      for (int i = 0; i < 3; i++) begin
         set_dec(7'h33, 0, i, i, 1);
         tick();
      end
      set_dec(7'h33, 2, 3, 3, 1); cb_commit = 1;
      tick();
      cb_commit = 0; set_dec(7'h00, 1, 4, 4, 1);
      #1;
      n_vec++; if (occupancy !== 5'd3) begin n_err++; $display("FAIL commit_accept_occ got %0d want 3", occupancy); end
      n_vec++; if (dec_ready !== 1'b1 || alloc_ena !== 1'b0) begin n_err++; $display("FAIL bubble_ready_alloc got %b/%b want 1/0", dec_ready, alloc_ena); end
      tick();
      dec_valid = 0;
      #1;
      n_vec++; if (occupancy !== 5'd3) begin n_err++; $display("FAIL bubble_occ got %0d want 3", occupancy); end
   endtask

   task automatic test_wrap_stats();
      do_reset();
      set_dec(7'h33, 0, 15, 1, 1);
      tick();
      set_dec(7'h33, 2, 0, 2, 0);
      #1;
      n_vec++; if (iss_index !== 4'd15) begin n_err++; $display("FAIL wrap_index_15 got %0d want 15", iss_index); end
      tick();
      cb_full = 1; set_dec(7'h33, 1, 1, 3, 1);
      #1;
      n_vec++; if (iss_index !== 4'd0 || iss_valid !== 4'b0100) begin n_err++; $display("FAIL wrap_index_0 got %0d/%b want 0/0100", iss_index, iss_valid); end
      for (int c = 0; c < 4; c++) begin
         #1;
         n_vec++; if (dec_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d] got %b want 0", c, dec_ready); end
         tick();
      end
      cb_full = 0; dec_valid = 0;
      #1;
`ifdef CB_DISPATCH_STATS_EN
      n_vec++; if (stall_full_cnt !== 32'd4) begin n_err++; $display("FAIL stats_stall got %0d want 4", stall_full_cnt); end
      n_vec++; if (dispatch_cnt !== 32'd2) begin n_err++; $display("FAIL stats_dispatch got %0d want 2", dispatch_cnt); end
`endif
   endtask

   task automatic test_async_reset();
      do_reset();
      iss_ready = 4'b0000;
      set_dec(7'h33, 3, 9, 5, 1);
      tick();
      dec_valid = 0;
      #2 RST = 1;
      #1;
      n_vec++; if (iss_valid !== 4'b0 || occupancy !== '0) begin n_err++; $display("FAIL async_reset got %b/%0d want 0000/0", iss_valid, occupancy); end
      n_vec++; if (dec_ready !== 1'b0) begin n_err++; $display("FAIL async_reset_ready got %b want 0", dec_ready); end
      tick();
      RST = 0;
      #1;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         dec_valid  = ($urandom % 4) != 0;
         dec_opcode = (($urandom % 6) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
         dec_fu     = 2'($urandom);
         dec_rd     = 5'($urandom);
         dec_wen    = 1'($urandom);
         cb_tail    = IW'($urandom);
         cb_full    = ($urandom % 10) == 0;
         cb_commit  = ($urandom % 3) == 0;
         flush      = ($urandom % 40) == 0;
         iss_ready  = 4'($urandom);
         #1;
         n_vec++; if (dec_ready !== exp_ready()) begin n_err++; $display("FAIL rnd_dec_ready c=%0d got %b want %b", c, dec_ready, exp_ready()); end
         n_vec++; if (alloc_ena !== exp_alloc()) begin n_err++; $display("FAIL rnd_alloc_ena c=%0d got %b want %b", c, alloc_ena, exp_alloc()); end
         n_vec++; if (exp_alloc() && alloc_opcode !== dec_opcode) begin n_err++; $display("FAIL rnd_alloc_opcode c=%0d got %h want %h", c, alloc_opcode, dec_opcode); end
         n_vec++; if (iss_valid !== exp_iss_valid()) begin n_err++; $display("FAIL rnd_iss_valid c=%0d got %b want %b", c, iss_valid, exp_iss_valid()); end
         n_vec++; if (occupancy !== (IW+1)'(m_occ)) begin n_err++; $display("FAIL rnd_occupancy c=%0d got %0d want %0d", c, occupancy, m_occ); end
         n_vec++; if (m_held && {iss_index, iss_rd, iss_wen} !== {IW'(m_idx), 5'(m_rd), 1'(m_wen)}) begin
            n_err++; $display("FAIL rnd_iss_fields c=%0d got %0d/%0d/%b want %0d/%0d/%0d", c, iss_index, iss_rd, iss_wen, m_idx, m_rd, m_wen);
         end
         tick();
      end
      idle_inputs();
      #1;
`ifdef CB_DISPATCH_STATS_EN
      n_vec++; if (stall_full_cnt !== 32'(m_stall)) begin n_err++; $display("FAIL rnd_stats_stall got %0d want %0d", stall_full_cnt, m_stall); end
      n_vec++; if (dispatch_cnt !== 32'(m_disp)) begin n_err++; $display("FAIL rnd_stats_dispatch got %0d want %0d", dispatch_cnt, m_disp); end
`endif
   endtask

   initial begin
      model_reset();
      idle_inputs();
      #1;
      test_reset();
      test_basic_issue();
      test_full();
      test_backpressure();
      test_flush();
      test_commit_bubble();
      test_wrap_stats();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
